// File: rtl/dram_refresh_arb.sv
// Purpose: arbitrates the 4-bank DRAM array between the CPU access sequencer and periodic CBR refresh.
// Latency: grant one clock after acc_req is sampled in IDLE; every output comes straight from a flop.
// Backpressure: acc_req is a held level; a grant is never preempted, and refresh wins in IDLE only at the pending ceiling.
//
// Ports:
//   clk          system clock, rising edge
//   nRESET       asynchronous active-low reset
//   acc_req      sequencer wants the array (level, held until acc_gnt)
//   acc_done     one-cycle pulse, sequencer finished including its precharge
//   acc_gnt      sequencer owns the array
//   ref_active   refresh sequence in progress (CSR, RAS, PRE)
//   nRAS_REF     refresh RAS per bank, active low, all banks switched together
//   nCAS_REF     refresh CAS, active low, fanned to every CAS line
//   ref_pending  refreshes owed
//   ref_overflow sticky; a refresh tick was lost at the ceiling
module dram_refresh_arb #(
  parameter int REF_PERIOD = 250,
  parameter int T_CSR      = 1,
  parameter int T_RAS      = 4,
  parameter int T_RP       = 3,
  parameter int MAX_PEND   = 3
) (
  input  logic       clk,
  input  logic       nRESET,
  input  logic       acc_req,
  input  logic       acc_done,
  output logic       acc_gnt,
  output logic       ref_active,
  output logic [3:0] nRAS_REF,
  output logic       nCAS_REF,
  output logic [1:0] ref_pending,
  output logic       ref_overflow
);

  localparam int T_MAX0 = (T_CSR > T_RAS) ? T_CSR : T_RAS;
  localparam int T_MAX  = (T_MAX0 > T_RP) ? T_MAX0 : T_RP;
  localparam int CW     = (T_MAX > 1) ? $clog2(T_MAX) : 1;
  localparam int TW     = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;

  localparam logic [TW-1:0] TIMER_LOAD = TW'(REF_PERIOD - 1);
  localparam logic [CW-1:0] CSR_LAST   = CW'(T_CSR - 1);
  localparam logic [CW-1:0] RAS_LAST   = CW'(T_RAS - 1);
  localparam logic [CW-1:0] RP_LAST    = CW'(T_RP - 1);
  localparam logic [1:0]    PEND_MAX   = 2'(MAX_PEND);

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    CSR,
    RAS,
    PRE
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [TW-1:0]   timer;
  logic            tick;
  logic            dec;

  // Tick fires on the clock where the timer sits at zero, so the period is
  // exactly REF_PERIOD clocks regardless of what the FSM is doing.
  assign tick = (timer == '0);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    dec       = 1'b0;
    case (state)
      IDLE: begin
        // Ceiling beats the CPU; otherwise the CPU beats ordinary refresh.
        if (ref_pending == PEND_MAX)  state_nxt = CSR;
        else if (acc_req)             state_nxt = GRANT;
        else if (ref_pending != 2'd0) state_nxt = CSR;
      end
      GRANT: begin
        if (acc_done) state_nxt = IDLE;
      end
      CSR: begin
        if (cnt == CSR_LAST) begin
          state_nxt = RAS;
          dec       = 1'b1;  // a refresh is consumed on RAS entry
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      RAS: begin
        if (cnt == RAS_LAST) state_nxt = PRE;
        else                 cnt_nxt   = cnt + CW'(1);
      end
      PRE: begin
        if (cnt == RP_LAST) state_nxt = IDLE;
        else                cnt_nxt   = cnt + CW'(1);
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      state <= IDLE;
      cnt   <= '0;
      timer <= TIMER_LOAD;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      timer <= tick ? TIMER_LOAD : (timer - TW'(1));
    end
  end

  // Pending count: simultaneous tick and consume cancel out.
  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      ref_pending  <= 2'd0;
      ref_overflow <= 1'b0;
    end else if (tick && !dec) begin
      if (ref_pending == PEND_MAX) ref_overflow <= 1'b1;
      else                         ref_pending  <= ref_pending + 2'd1;
    end else if (dec && !tick) begin
      ref_pending <= ref_pending - 2'd1;
    end
  end

  // Outputs are decoded from the next state and registered, so they line up
  // with the state register and reset releases every strobe immediately.
  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      acc_gnt    <= 1'b0;
      ref_active <= 1'b0;
      nRAS_REF   <= 4'hF;
      nCAS_REF   <= 1'b1;
    end else begin
      acc_gnt    <= (state_nxt == GRANT);
      ref_active <= (state_nxt == CSR) || (state_nxt == RAS) || (state_nxt == PRE);
      nRAS_REF   <= (state_nxt == RAS) ? 4'h0 : 4'hF;
      nCAS_REF   <= !((state_nxt == CSR) || (state_nxt == RAS));
    end
  end

endmodule

// File: tb/tb_dram_refresh_arb.sv
// Directed bench for dram_refresh_arb: refresh timing, CPU grant, pending
// saturation and overflow, asynchronous reset in RAS, tick on RAS entry.
module tb_dram_refresh_arb;

  logic       clk = 1'b0;
  logic       nRESET = 1'b1;
  logic       acc_req = 1'b0;
  logic       acc_done = 1'b0;
  logic       acc_gnt;
  logic       ref_active;
  logic [3:0] nRAS_REF;
  logic       nCAS_REF;
  logic [1:0] ref_pending;
  logic       ref_overflow;

  int cyc;
  int checks = 0;
  int failures = 0;

  dram_refresh_arb dut (
    .clk          (clk),
    .nRESET       (nRESET),
    .acc_req      (acc_req),
    .acc_done     (acc_done),
    .acc_gnt      (acc_gnt),
    .ref_active   (ref_active),
    .nRAS_REF     (nRAS_REF),
    .nCAS_REF     (nCAS_REF),
    .ref_pending  (ref_pending),
    .ref_overflow (ref_overflow)
  );

  always #5 clk = ~clk;

  // Clock count since reset release: cyc==k means k rising edges have been seen.
  always @(posedge clk or negedge nRESET) begin
    if (!nRESET) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to the falling edge following rising edge n.
  task automatic at(input int n);
    int guard;
    guard = 0;
    while (cyc < n && guard < 6000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != n) begin
      failures++;
      $display("FAIL wait_cyc observed=%0d expected=%0d", cyc, n);
    end
  endtask

  initial begin
    #1 nRESET = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_gnt",      acc_gnt,      0);
    chk("rst_active",   ref_active,   0);
    chk("rst_nras",     nRAS_REF,     4'hF);
    chk("rst_ncas",     nCAS_REF,     1);
    chk("rst_pending",  ref_pending,  0);
    chk("rst_overflow", ref_overflow, 0);
    nRESET = 1'b1;

    // First refresh: tick at clock 250, CSR 251, RAS 252-255, PRE 256-258.
    at(249); chk("t1_pend_249", ref_pending, 0);
    at(250); chk("t1_pend_250", ref_pending, 1);
             chk("t1_idle_250", ref_active, 0);
    at(251); chk("t1_csr_ncas", nCAS_REF, 0);
             chk("t1_csr_nras", nRAS_REF, 4'hF);
             chk("t1_csr_act",  ref_active, 1);
    at(252); chk("t1_ras_nras", nRAS_REF, 4'h0);
             chk("t1_ras_ncas", nCAS_REF, 0);
             chk("t1_ras_pend", ref_pending, 0);
    at(255); chk("t1_ras_last", nRAS_REF, 4'h0);
    at(256); chk("t1_pre_nras", nRAS_REF, 4'hF);
             chk("t1_pre_ncas", nCAS_REF, 1);
             chk("t1_pre_act",  ref_active, 1);
    at(258); chk("t1_pre_last", ref_active, 1);
    at(259); chk("t1_idle",     ref_active, 0);

    // CPU grant one clock after acc_req is sampled; released after acc_done.
    at(260); acc_req = 1'b1;
             chk("t2_gnt_260", acc_gnt, 0);
    at(261); chk("t2_gnt_261", acc_gnt, 1);
             chk("t2_act_261", ref_active, 0);
    at(265); acc_done = 1'b1; acc_req = 1'b0;
    at(266); acc_done = 1'b0;
             chk("t2_gnt_266", acc_gnt, 0);
    at(268); chk("t2_gnt_268", acc_gnt, 0);

    // Ticks during grants accumulate; CPU keeps winning below the ceiling.
    at(480); acc_req = 1'b1;
    at(481); chk("t3_gnt_481",  acc_gnt, 1);
    at(500); chk("t3_pend_500", ref_pending, 1);
             chk("t3_gnt_500",  acc_gnt, 1);
    at(509); acc_done = 1'b1; acc_req = 1'b0;
    at(510); acc_done = 1'b0; acc_req = 1'b1;
             chk("t3_gnt_510", acc_gnt, 0);
             chk("t3_act_510", ref_active, 0);
    at(511); chk("t3_gnt_511", acc_gnt, 1);
    at(750); chk("t3_pend_750", ref_pending, 2);
    at(760); acc_done = 1'b1;
    at(761); acc_done = 1'b0;
             chk("t3_gnt_761", acc_gnt, 0);
    at(762); chk("t3_gnt_762",  acc_gnt, 1);
             chk("t3_pend_762", ref_pending, 2);
    at(765); acc_done = 1'b1; acc_req = 1'b0;
    at(766); acc_done = 1'b0;
    at(767); chk("t3_csr_a",  ref_active, 1);
             chk("t3_ncas_a", nCAS_REF, 0);
    at(768); chk("t3_pend_768", ref_pending, 1);
    at(775); chk("t3_gap",    ref_active, 0);
    at(776); chk("t3_csr_b",  ref_active, 1);
    at(777); chk("t3_pend_777", ref_pending, 0);
    at(784); chk("t3_done", ref_active, 0);

    // Long grant: pending saturates at 3 and the fourth tick overflows.
    at(790);  acc_req = 1'b1;
    at(1000); chk("t4_pend_1000", ref_pending, 1);
    at(1500); chk("t4_pend_1500", ref_pending, 3);
    at(1749); chk("t4_ovf_1749",  ref_overflow, 0);
    at(1750); chk("t4_ovf_1750",  ref_overflow, 1);
              chk("t4_pend_1750", ref_pending, 3);
    at(1760); acc_done = 1'b1;
    at(1761); acc_done = 1'b0;
              chk("t4_gnt_1761", acc_gnt, 0);
    // At the ceiling refresh is taken even though acc_req is high.
    at(1762); chk("t4_csr_act",  ref_active, 1);
              chk("t4_csr_gnt",  acc_gnt, 0);
    at(1763); chk("t4_pend_1763", ref_pending, 2);
    at(1766); acc_req = 1'b0;
    at(1770); chk("t4_gap_1", ref_active, 0);
    at(1771); chk("t4_csr_2", ref_active, 1);
    at(1772); chk("t4_pend_1772", ref_pending, 1);
    at(1779); chk("t4_gap_2", ref_active, 0);
    at(1780); chk("t4_csr_3", ref_active, 1);
    at(1781); chk("t4_pend_1781", ref_pending, 0);
    at(1785); acc_req = 1'b1;
    at(1788); chk("t4_gnt_1788", acc_gnt, 0);
              chk("t4_act_1788", ref_active, 0);
    at(1789); chk("t4_gnt_1789", acc_gnt, 1);
              chk("t4_ovf_sticky", ref_overflow, 1);
    at(1795); acc_done = 1'b1; acc_req = 1'b0;
    at(1796); acc_done = 1'b0;

    // Reset asserted in RAS releases the strobes without waiting for a clock.
    at(2003); chk("t5_in_ras", nRAS_REF, 4'h0);
              nRESET = 1'b0;
              #1;
              chk("t5_async_nras", nRAS_REF, 4'hF);
              chk("t5_async_ncas", nCAS_REF, 1);
              chk("t5_async_act",  ref_active, 0);
              chk("t5_async_ovf",  ref_overflow, 0);
    repeat (2) @(negedge clk);
    nRESET = 1'b1;
    at(1);    chk("t5_post_act",  ref_active, 0);
              chk("t5_post_gnt",  acc_gnt, 0);
              chk("t5_post_pend", ref_pending, 0);
              chk("t5_post_ovf",  ref_overflow, 0);

    // Tick on the same clock as RAS entry leaves pending unchanged.
    at(200); acc_req = 1'b1;
    at(250); chk("t6_pend_250", ref_pending, 1);
    at(497); acc_done = 1'b1; acc_req = 1'b0;
    at(498); acc_done = 1'b0;
    at(499); chk("t6_csr", nCAS_REF, 0);
    at(500); chk("t6_ras_nras", nRAS_REF, 4'h0);
             chk("t6_pend_500", ref_pending, 1);
             chk("t6_ovf_500",  ref_overflow, 0);
    at(507); chk("t6_gap", ref_active, 0);
    at(508); chk("t6_csr_2", ref_active, 1);
    at(509); chk("t6_pend_509", ref_pending, 0);
             chk("t6_ovf_509",  ref_overflow, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dram_refresh_arb.md
Name: dram_refresh_arb

Overview:
- Owns the shared DRAM array (4 RAS banks, modules A-D). Arbitrates between the CPU access sequencer and periodic CAS-before-RAS (CBR) refresh.
- Generates the refresh request timer, a pending-refresh count and the CBR strobe sequence.
- Grants the array to the access sequencer when no refresh is due.
- Sits inside dram, alongside the access state machine. Its refresh strobes are ANDed (active-low) with the sequencer's RAS/CAS at the top level.

Parameters:
REF_PERIOD, 250, clocks between refresh requests (15.6 us at 16 MHz)
T_CSR, 1, clocks CAS low before RAS falls (CBR setup)
T_RAS, 4, clocks RAS held low during refresh
T_RP, 3, clocks RAS/CAS precharge after refresh before the array is free
MAX_PEND, 3, pending-refresh ceiling; at this level refresh preempts CPU requests

Ports:
clk  in  1  system clock; all state changes on rising edge
nRESET  in  1  asynchronous active-low reset
acc_req  in  1  sequencer requests the array; level, held until acc_gnt seen
acc_done  in  1  one-cycle pulse; sequencer finished, including its own precharge
acc_gnt  out  1  level; sequencer owns the array
ref_active  out  1  high while FSM is in CSR, RAS or PRE
nRAS_REF  out  4  refresh RAS, one per bank, all switched together
nCAS_REF  out  1  refresh CAS, fanned to all 16 CAS lines
ref_pending  out  2  current pending-refresh count
ref_overflow  out  1  sticky; a refresh request was lost at saturation

Behaviour:
- Reset (async, immediate): acc_gnt=0, ref_active=0, nRAS_REF=4'hF, nCAS_REF=1, ref_pending=0, ref_overflow=0, timer=REF_PERIOD-1, FSM=IDLE. Reset during refresh or grant releases all strobes at once; no completion is owed.
- All outputs are registered. No combinational path from inputs to outputs.
- Timer:
  - Free-running down-counter, decrements every clock.
  - At 0 it reloads REF_PERIOD-1 and issues a tick.
  - Tick period is exactly REF_PERIOD clocks, independent of FSM state.
- Pending count:
  - A tick increments ref_pending.
  - Entering the RAS state decrements it.
  - Tick and decrement in the same cycle leave the count unchanged.
  - A tick when ref_pending==MAX_PEND with no decrement that cycle leaves the count at MAX_PEND and sets ref_overflow. ref_overflow clears only on reset.
- FSM states: IDLE, GRANT, CSR, RAS, PRE.
- IDLE, priority order:
  - (1) ref_pending==MAX_PEND -> CSR.
  - (2) acc_req -> GRANT.
  - (3) ref_pending!=0 -> CSR.
  - (4) else stay.
  - Decision uses the registered ref_pending value in that cycle.
- GRANT:
  - acc_gnt=1 from the first GRANT cycle, i.e. one clock after acc_req is sampled in IDLE.
  - acc_done -> IDLE; acc_gnt=0 in the next cycle.
  - Refresh never preempts an active grant. The sequencer bounds its access length; ticks keep accumulating meanwhile.
- CSR: nCAS_REF=0, nRAS_REF=F, for T_CSR cycles, then -> RAS.
- RAS: nCAS_REF=0, nRAS_REF=0, for T_RAS cycles, then -> PRE.
- PRE:
  - nCAS_REF=1, nRAS_REF=F, for T_RP cycles, then -> IDLE.
  - The IDLE decision happens on the next cycle, so back-to-back refreshes are separated by exactly 1 IDLE cycle.
- acc_done outside GRANT is ignored. acc_req outside IDLE is ignored until the FSM returns to IDLE; the sequencer keeps it high.
- ref_active=1 in CSR, RAS and PRE only. acc_gnt and ref_active are never both 1.
- State counters are sized for max(T_CSR, T_RAS, T_RP). A parameter value of 0 is illegal.

Test Plan:
- Reset release, no requests -> first tick at clock 250; ref_pending 0->1; CSR next cycle; nCAS_REF low 1 clk, then nRAS_REF=0 for 4 clks (with nCAS_REF still low), then 3 clks precharge; ref_pending back to 0.
- acc_req held high from reset, ref_pending=0 -> acc_gnt=1 one clock after first sampled; acc_done pulse -> acc_gnt=0 next cycle.
- Tick arrives mid-GRANT with ref_pending=1, acc_req re-asserted in same cycle acc_done falls -> GRANT continues to end; next IDLE grants CPU again (pending 2 < 3); refresh runs only when acc_req is low.
- Hold grant for 4*REF_PERIOD clocks -> ref_pending saturates at 3, ref_overflow=1. After release, refresh is taken even with acc_req high, three back-to-back CBRs each separated by 1 IDLE cycle, then CPU granted.
- Assert nRESET low during RAS state -> nRAS_REF=F and nCAS_REF=1 immediately (asynchronously). After release: IDLE, ref_pending=0, ref_overflow=0.
- Force tick in the same cycle as the RAS entry decrement (ref_pending=1) -> ref_pending stays 1, no overflow.
